block_lock_ctrl: RTL and testbench

//  Sequences 66b block-header alignment search for one Rx lane. Accepts candidate header offsets

---
 rtl/block_lock_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_block_lock_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_lock_ctrl.sv
// 66b block-lock sequencer for one Rx lane: commits seeker candidates, qualifies them
// over consecutive valid headers, monitors errors while locked and restarts the seeker.
module block_lock_ctrl #(
  parameter int unsigned OFFSET_W   = 7,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned ERR_WINDOW = 64,
  parameter int unsigned ERR_MAX    = 16,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [OFFSET_W-1:0] cand_offset_i,
  input  logic                cand_dv_i,
  input  logic [1:0]          hdr_i,
  input  logic                hdr_dv_i,
  input  logic                force_resync_i,
  output logic [OFFSET_W-1:0] offset_o,
  output logic                offset_dv_o,
  output logic                seeker_rst_o,
  output logic                locked_o,
  output logic [2:0]          state_o,
  output logic [7:0]          relock_cnt_o
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(ERR_WINDOW + 1);
  localparam int unsigned EW = $clog2(ERR_MAX + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

  localparam logic [GW-1:0]       GOOD_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0]       WIN_FULL    = WW'(ERR_WINDOW);
  localparam logic [EW-1:0]       ERR_LIMIT   = EW'(ERR_MAX);
  localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [OFFSET_W-1:0] MAX_OFFSET  = OFFSET_W'(65);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SEARCH = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                offset_dv_q, offset_dv_d;
  logic                seeker_rst_q, seeker_rst_d;
  logic                locked_q, locked_d;
  logic [7:0]          relock_q, relock_d;
  logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [GW-1:0]       good_cnt_q, good_cnt_d;
  logic [WW-1:0]       win_cnt_q, win_cnt_d;
  logic [EW-1:0]       err_cnt_q, err_cnt_d;

  logic          hdr_ok;
  logic          restart;
  logic          bump_relock;
  logic [WW-1:0] win_nxt;
  logic [EW-1:0] err_nxt;

  assign hdr_ok = (hdr_i == 2'b01) || (hdr_i == 2'b10);

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    offset_dv_d  = offset_dv_q;
    seeker_rst_d = 1'b0;
    locked_d     = locked_q;
    relock_d     = relock_q;
    settle_cnt_d = settle_cnt_q;
    good_cnt_d   = good_cnt_q;
    win_cnt_d    = win_cnt_q;
    err_cnt_d    = err_cnt_q;
    restart      = 1'b0;
    bump_relock  = 1'b0;
    win_nxt      = win_cnt_q + WW'(1);
    err_nxt      = err_cnt_q + (hdr_ok ? '0 : EW'(1));

    if (!en_i) begin
      state_d      = ST_IDLE;
      offset_dv_d  = 1'b0;
      locked_d     = 1'b0;
      settle_cnt_d = '0;
      good_cnt_d   = '0;
      win_cnt_d    = '0;
      err_cnt_d    = '0;
    end else begin
      unique case (state_q)
        // Only way to sit in IDLE with en_i high is an enable rising edge.
        ST_IDLE: restart = 1'b1;
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ST_SEARCH;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end
        ST_SEARCH: begin
          if (force_resync_i) begin
            restart = 1'b1;
          end else if (cand_dv_i && (cand_offset_i <= MAX_OFFSET)) begin
            offset_d    = cand_offset_i;
            offset_dv_d = 1'b1;
            good_cnt_d  = '0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (force_resync_i) begin
            restart = 1'b1;
          end else if (hdr_dv_i) begin
            if (!hdr_ok) begin
              restart = 1'b1;
            end else if (good_cnt_q == GOOD_LAST) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = '0;
              win_cnt_d  = '0;
              err_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (force_resync_i) begin
            restart     = 1'b1;
            bump_relock = 1'b1;
          end else if (hdr_dv_i) begin
            // Error limit checked before the window wrap so a last-header error still counts.
            if (err_nxt == ERR_LIMIT) begin
              restart     = 1'b1;
              bump_relock = 1'b1;
            end else if (win_nxt == WIN_FULL) begin
              win_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              win_cnt_d = win_nxt;
              err_cnt_d = err_nxt;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (restart) begin
      state_d      = ST_SETTLE;
      seeker_rst_d = 1'b1;
      offset_dv_d  = 1'b0;
      locked_d     = 1'b0;
      settle_cnt_d = '0;
      good_cnt_d   = '0;
      win_cnt_d    = '0;
      err_cnt_d    = '0;
    end
    if (bump_relock && (relock_q != 8'hFF)) begin
      relock_d = relock_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      offset_q     <= '0;
      offset_dv_q  <= 1'b0;
      seeker_rst_q <= 1'b0;
      locked_q     <= 1'b0;
      relock_q     <= '0;
      settle_cnt_q <= '0;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      offset_dv_q  <= offset_dv_d;
      seeker_rst_q <= seeker_rst_d;
      locked_q     <= locked_d;
      relock_q     <= relock_d;
      settle_cnt_q <= settle_cnt_d;
      good_cnt_q   <= good_cnt_d;
      win_cnt_q    <= win_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign offset_o     = offset_q;
  assign offset_dv_o  = offset_dv_q;
  assign seeker_rst_o = seeker_rst_q;
  assign locked_o     = locked_q;
  assign state_o      = state_q;
  assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Directed bench for block_lock_ctrl: settle timing, lock qualification, error window,
// forced resync, enable drop and asynchronous reset.
module tb_block_lock_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic [6:0] cand_offset_i;
  logic       cand_dv_i;
  logic [1:0] hdr_i;
  logic       hdr_dv_i;
  logic       force_resync_i;
  logic [6:0] offset_o;
  logic       offset_dv_o;
  logic       seeker_rst_o;
  logic       locked_o;
  logic [2:0] state_o;
  logic [7:0] relock_cnt_o;

  int checks   = 0;
  int failures = 0;

  block_lock_ctrl #(
    .OFFSET_W  (7),
    .LOCK_CNT  (32),
    .ERR_WINDOW(64),
    .ERR_MAX   (16),
    .SETTLE_CYC(16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .cand_offset_i (cand_offset_i),
    .cand_dv_i     (cand_dv_i),
    .hdr_i         (hdr_i),
    .hdr_dv_i      (hdr_dv_i),
    .force_resync_i(force_resync_i),
    .offset_o      (offset_o),
    .offset_dv_o   (offset_dv_o),
    .seeker_rst_o  (seeker_rst_o),
    .locked_o      (locked_o),
    .state_o       (state_o),
    .relock_cnt_o  (relock_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_hdr(input logic [1:0] h);
    hdr_i    = h;
    hdr_dv_i = 1'b1;
    tick();
    hdr_dv_i = 1'b0;
  endtask

  task automatic wait_search(input string tag);
    int n = 0;
    while (state_o !== 3'd2 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (state_o !== 3'd2) begin
      failures++;
      $display("FAIL %s_reach_search state=%0d required=2", tag, state_o);
    end
  endtask

  task automatic commit_and_lock(input logic [6:0] off, input string tag);
    cand_offset_i = off;
    cand_dv_i     = 1'b1;
    tick();
    cand_dv_i = 1'b0;
    for (int i = 0; i < 32; i++) send_hdr((i % 2 == 0) ? 2'b01 : 2'b10);
    checks++;
    if (locked_o !== 1'b1 || state_o !== 3'd4) begin
      failures++;
      $display("FAIL %s_lock locked=%0b state=%0d required locked=1 state=4", tag, locked_o, state_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0; cand_offset_i = '0; cand_dv_i = 1'b0;
    hdr_i = 2'b00; hdr_dv_i = 1'b0; force_resync_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({state_o, offset_o, offset_dv_o, seeker_rst_o, locked_o, relock_cnt_o} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs state=%0d off=%0d dv=%0b srst=%0b lock=%0b relock=%0d required all 0",
               state_o, offset_o, offset_dv_o, seeker_rst_o, locked_o, relock_cnt_o);
    end
    rst_ni = 1'b1;
    repeat (2) tick();
    checks++;
    if (state_o !== 3'd0 || seeker_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold state=%0d srst=%0b required 0/0", state_o, seeker_rst_o);
    end
  endtask

  task automatic test_enable_settle();
    int n;
    int pulses;
    en_i = 1'b1;
    tick();
    checks++;
    if (state_o !== 3'd1 || seeker_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL enable_pulse state=%0d srst=%0b required 1/1", state_o, seeker_rst_o);
    end
    cand_offset_i = 7'd5;
    cand_dv_i     = 1'b1;
    hdr_i         = 2'b11;
    hdr_dv_i      = 1'b1;
    n = 1; pulses = 1;
    while (state_o === 3'd1 && n < 40) begin
      tick();
      if (seeker_rst_o) pulses++;
      if (state_o === 3'd1) n++;
    end
    cand_dv_i = 1'b0;
    hdr_dv_i  = 1'b0;
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL settle_len cycles=%0d required=16", n);
    end
    checks++;
    if (state_o !== 3'd2 || offset_dv_o !== 1'b0) begin
      failures++;
      $display("FAIL settle_exit state=%0d dv=%0b required 2/0", state_o, offset_dv_o);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL seeker_pulse_count pulses=%0d required=1", pulses);
    end
  endtask

  task automatic test_lock();
    cand_offset_i = 7'd66;
    cand_dv_i     = 1'b1;
    tick();
    cand_dv_i = 1'b0;
    checks++;
    if (state_o !== 3'd2 || offset_dv_o !== 1'b0) begin
      failures++;
      $display("FAIL cand66_ignored state=%0d dv=%0b required 2/0", state_o, offset_dv_o);
    end
    cand_offset_i = 7'd23;
    cand_dv_i     = 1'b1;
    tick();
    cand_dv_i = 1'b0;
    checks++;
    if (state_o !== 3'd3 || offset_o !== 7'd23 || offset_dv_o !== 1'b1) begin
      failures++;
      $display("FAIL commit state=%0d off=%0d dv=%0b required 3/23/1", state_o, offset_o, offset_dv_o);
    end
    hdr_i = 2'b11;
    tick();
    for (int i = 0; i < 31; i++) begin
      cand_offset_i = 7'd40;
      cand_dv_i     = (i == 5);
      send_hdr((i % 2 == 0) ? 2'b01 : 2'b10);
    end
    cand_dv_i = 1'b0;
    checks++;
    if (state_o !== 3'd3 || locked_o !== 1'b0 || offset_o !== 7'd23) begin
      failures++;
      $display("FAIL verify_31 state=%0d lock=%0b off=%0d required 3/0/23", state_o, locked_o, offset_o);
    end
    send_hdr(2'b10);
    checks++;
    if (state_o !== 3'd4 || locked_o !== 1'b1 || offset_dv_o !== 1'b1) begin
      failures++;
      $display("FAIL verify_32 state=%0d lock=%0b dv=%0b required 4/1/1", state_o, locked_o, offset_dv_o);
    end
  endtask

  task automatic test_err_window();
    for (int i = 0; i < 64; i++) send_hdr((i < 14 || i == 63) ? 2'b11 : 2'b01);
    for (int i = 0; i < 64; i++) send_hdr((i < 15) ? 2'b00 : 2'b10);
    checks++;
    if (locked_o !== 1'b1 || relock_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL window_15_errs lock=%0b relock=%0d required 1/0", locked_o, relock_cnt_o);
    end
    for (int i = 0; i < 63; i++) send_hdr((i < 15) ? 2'b11 : 2'b01);
    checks++;
    if (locked_o !== 1'b1 || state_o !== 3'd4) begin
      failures++;
      $display("FAIL window_pre_last lock=%0b state=%0d required 1/4", locked_o, state_o);
    end
    send_hdr(2'b00);
    checks++;
    if (locked_o !== 1'b0 || state_o !== 3'd1 || seeker_rst_o !== 1'b1 || relock_cnt_o !== 8'd1
        || offset_dv_o !== 1'b0 || offset_o !== 7'd23) begin
      failures++;
      $display("FAIL window_16th_err lock=%0b state=%0d srst=%0b relock=%0d dv=%0b off=%0d required 0/1/1/1/0/23",
               locked_o, state_o, seeker_rst_o, relock_cnt_o, offset_dv_o, offset_o);
    end
    tick();
    checks++;
    if (seeker_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL restart_pulse_width srst=%0b required=0", seeker_rst_o);
    end
  endtask

  task automatic test_verify_fail();
    bit saw_lock = 1'b0;
    wait_search("vfail");
    cand_offset_i = 7'd7;
    cand_dv_i     = 1'b1;
    tick();
    cand_dv_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_hdr(2'b01);
      if (locked_o) saw_lock = 1'b1;
    end
    send_hdr(2'b11);
    if (locked_o) saw_lock = 1'b1;
    checks++;
    if (seeker_rst_o !== 1'b1 || state_o !== 3'd1 || offset_dv_o !== 1'b0 || saw_lock) begin
      failures++;
      $display("FAIL verify_bad_hdr srst=%0b state=%0d dv=%0b saw_lock=%0b required 1/1/0/0",
               seeker_rst_o, state_o, offset_dv_o, saw_lock);
    end
    checks++;
    if (relock_cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL verify_no_relock relock=%0d required=1", relock_cnt_o);
    end
  endtask

  task automatic test_force_resync();
    tick();
    force_resync_i = 1'b1;
    tick();
    force_resync_i = 1'b0;
    checks++;
    if (state_o !== 3'd1 || seeker_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL force_in_settle state=%0d srst=%0b required 1/0", state_o, seeker_rst_o);
    end
    wait_search("force");
    commit_and_lock(7'd5, "force");
    force_resync_i = 1'b1;
    tick();
    force_resync_i = 1'b0;
    checks++;
    if (state_o !== 3'd1 || seeker_rst_o !== 1'b1 || locked_o !== 1'b0 || relock_cnt_o !== 8'd2
        || offset_o !== 7'd5) begin
      failures++;
      $display("FAIL force_locked state=%0d srst=%0b lock=%0b relock=%0d off=%0d required 1/1/0/2/5",
               state_o, seeker_rst_o, locked_o, relock_cnt_o, offset_o);
    end
  endtask

  task automatic test_enable_drop();
    int pulses = 0;
    wait_search("endrop");
    commit_and_lock(7'd9, "endrop");
    en_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd0 || locked_o !== 1'b0 || offset_dv_o !== 1'b0 || relock_cnt_o !== 8'd2) begin
      failures++;
      $display("FAIL en_drop state=%0d lock=%0b dv=%0b relock=%0d required 0/0/0/2",
               state_o, locked_o, offset_dv_o, relock_cnt_o);
    end
    if (seeker_rst_o) pulses++;
    repeat (3) begin
      tick();
      if (seeker_rst_o) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL en_drop_no_pulse pulses=%0d required=0", pulses);
    end
  endtask

  task automatic test_async_reset();
    en_i = 1'b1;
    tick();
    wait_search("arst");
    cand_offset_i = 7'd44;
    cand_dv_i     = 1'b1;
    tick();
    cand_dv_i = 1'b0;
    for (int i = 0; i < 5; i++) send_hdr(2'b01);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({state_o, offset_o, offset_dv_o, seeker_rst_o, locked_o, relock_cnt_o} !== 21'd0) begin
      failures++;
      $display("FAIL async_reset state=%0d off=%0d dv=%0b srst=%0b lock=%0b relock=%0d required all 0",
               state_o, offset_o, offset_dv_o, seeker_rst_o, locked_o, relock_cnt_o);
    end
    en_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    checks++;
    if (state_o !== 3'd0 || seeker_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release state=%0d srst=%0b required 0/0", state_o, seeker_rst_o);
    end
  endtask

  initial begin
    test_reset();
    test_enable_settle();
    test_lock();
    test_err_window();
    test_verify_fail();
    test_force_resync();
    test_enable_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required finish before 200000", $time);
    $fatal(1);
  end

endmodule
